// File: rtl/cache_mem_pkg.sv
// Shared encodings and geometry for the cache/main-memory arbiter.
// Line offset = word-in-line beat index plus one byte-in-word bit.
package cache_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_FILL_I = 3'd2,
    ST_FILL_D = 3'd3,
    ST_DRAIN  = 3'd4
  } arb_state_e;

  localparam int BEATS_DEF     = 8;
  localparam int MEM_LAT_DEF   = 4;
  localparam int BYTE_OFF_BITS = 1;

  // Lowest address bit that belongs to the line number.
  function automatic int line_lsb(input int beats);
    return $clog2(beats) + BYTE_OFF_BITS;
  endfunction

endpackage

// File: rtl/mem_owner_pipe.sv
// MEM_LAT-stage shift register of {is_i, is_d} tags that tracks which cache
// owns each outstanding memory read; the tail lines up with the returning data.
module mem_owner_pipe #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] tag_in,
  output logic [1:0] tag_tail
);

  logic [1:0] stage_r [DEPTH];

  // Shift one tag per cycle; reset drops every in-flight owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= 2'b00;
      end
    end else begin
      stage_r[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign tag_tail = stage_r[DEPTH-1];

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the pipelined memory port between I-fill, D-fill and D stores,
// sequencing 8-beat line fills. Define ARB_ROUND_ROBIN_EN to alternate fill priority.
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int BEATS   = BEATS_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_grant,
  output logic              ic_data_valid,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  output logic              dc_grant,
  output logic              dc_data_valid,
  input  logic              dc_wr_req,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [DATA_W-1:0] dc_wr_data,
  output logic              dc_wr_ack,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_data_valid,
  output logic              busy
);

  localparam int BEAT_W   = $clog2(BEATS);
  localparam int LINE_LSB = line_lsb(BEATS);
  localparam int LINE_W   = ADDR_W - LINE_LSB;
  localparam int DRN_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEATS - 1);
  localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(MEM_LAT - 2);

  arb_state_e        state_r, state_nx_s;
  logic [BEAT_W-1:0] beat_r, beat_nx_s;
  logic [DRN_W-1:0]  drain_r, drain_nx_s;
  logic [LINE_W-1:0] line_r, line_nx_s;
  logic              pick_d_s;

  logic              ic_grant_r, dc_grant_r, dc_wr_ack_r, mem_enable_r, mem_wr_r, busy_r;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_nx_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nx_s;
  logic [1:0]        owner_tail_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_fill_i_r, last_fill_i_nx_s;

  // Last fill went to I: D wins a tie; last fill went to D: I wins a tie.
  always_comb begin
    pick_d_s = dc_req & (~ic_req | last_fill_i_r);
  end
`else
  // Fixed priority: a D fill always beats an I fill.
  always_comb begin
    pick_d_s = dc_req;
  end
`endif

  // Next-state logic plus the values every registered output takes next cycle.
  always_comb begin
    state_nx_s     = state_r;
    beat_nx_s      = beat_r;
    drain_nx_s     = drain_r;
    line_nx_s      = line_r;
    mem_addr_nx_s  = {ADDR_W{1'b0}};
    mem_wdata_nx_s = {DATA_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (dc_wr_req) begin
          state_nx_s     = ST_WRITE;
          mem_addr_nx_s  = dc_wr_addr;
          mem_wdata_nx_s = dc_wr_data;
        end else if (pick_d_s) begin
          state_nx_s = ST_FILL_D;
          line_nx_s  = dc_addr[ADDR_W-1:LINE_LSB];
        end else if (ic_req) begin
          state_nx_s = ST_FILL_I;
          line_nx_s  = ic_addr[ADDR_W-1:LINE_LSB];
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_nx_s = ST_IDLE;
      end
      ST_FILL_I, ST_FILL_D: begin
        if (beat_r == BEAT_LAST) begin
          beat_nx_s  = {BEAT_W{1'b0}};
          drain_nx_s = {DRN_W{1'b0}};
          state_nx_s = ST_DRAIN;
        end else begin
          beat_nx_s = beat_r + BEAT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          drain_nx_s = {DRN_W{1'b0}};
          state_nx_s = ST_IDLE;
        end else begin
          drain_nx_s = drain_r + DRN_W'(1);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        beat_nx_s  = {BEAT_W{1'b0}};
        drain_nx_s = {DRN_W{1'b0}};
      end
    endcase
    if ((state_nx_s == ST_FILL_I) || (state_nx_s == ST_FILL_D)) begin
      mem_addr_nx_s = {line_nx_s, beat_nx_s, 1'b0};
    end else begin
      mem_addr_nx_s = mem_addr_nx_s;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember which cache won the most recent fill.
  always_comb begin
    if ((state_r == ST_IDLE) && (state_nx_s == ST_FILL_I)) begin
      last_fill_i_nx_s = 1'b1;
    end else if ((state_r == ST_IDLE) && (state_nx_s == ST_FILL_D)) begin
      last_fill_i_nx_s = 1'b0;
    end else begin
      last_fill_i_nx_s = last_fill_i_r;
    end
  end

  // Fill-history register for round-robin tie breaks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_fill_i_r <= 1'b0;
    end else begin
      last_fill_i_r <= last_fill_i_nx_s;
    end
  end
`endif

  // FSM state, counters and latched line number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      beat_r  <= {BEAT_W{1'b0}};
      drain_r <= {DRN_W{1'b0}};
      line_r  <= {LINE_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      beat_r  <= beat_nx_s;
      drain_r <= drain_nx_s;
      line_r  <= line_nx_s;
    end
  end

  // Output registers; grants persist from fill start through the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_grant_r   <= 1'b0;
      dc_grant_r   <= 1'b0;
      dc_wr_ack_r  <= 1'b0;
      mem_enable_r <= 1'b0;
      mem_wr_r     <= 1'b0;
      busy_r       <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
    end else begin
      ic_grant_r   <= (state_nx_s == ST_FILL_I) | ((state_nx_s == ST_DRAIN) & ic_grant_r);
      dc_grant_r   <= (state_nx_s == ST_FILL_D) | ((state_nx_s == ST_DRAIN) & dc_grant_r);
      dc_wr_ack_r  <= (state_nx_s == ST_WRITE);
      mem_wr_r     <= (state_nx_s == ST_WRITE);
      mem_enable_r <= (state_nx_s == ST_WRITE) | (state_nx_s == ST_FILL_I) |
                      (state_nx_s == ST_FILL_D);
      busy_r       <= (state_nx_s != ST_IDLE);
      mem_addr_r   <= mem_addr_nx_s;
      mem_wdata_r  <= mem_wdata_nx_s;
    end
  end

  mem_owner_pipe #(
    .DEPTH (MEM_LAT)
  ) u_owner_pipe (
    .clk      (clk),
    .rst      (rst),
    .tag_in   ({state_r == ST_FILL_I, state_r == ST_FILL_D}),
    .tag_tail (owner_tail_s)
  );

  assign ic_data_valid = mem_data_valid & owner_tail_s[1];
  assign dc_data_valid = mem_data_valid & owner_tail_s[0];
  assign ic_grant      = ic_grant_r;
  assign dc_grant      = dc_grant_r;
  assign dc_wr_ack     = dc_wr_ack_r;
  assign mem_enable    = mem_enable_r;
  assign mem_wr        = mem_wr_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter: a transaction-level schedule model
// predicts every cycle's memory strobes, grants and data-valid routing.
module tb_cache_mem_arbiter;

  localparam int RING = 64;
  localparam int LAT  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_req = 1'b0, dc_req = 1'b0, dc_wr_req = 1'b0, mem_data_valid = 1'b0;
  logic [15:0] ic_addr = 16'h0, dc_addr = 16'h0, dc_wr_addr = 16'h0, dc_wr_data = 16'h0;
  logic        ic_grant, ic_data_valid, dc_grant, dc_data_valid, dc_wr_ack;
  logic        mem_enable, mem_wr, busy;
  logic [15:0] mem_addr, mem_wdata;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_grant(ic_grant), .ic_data_valid(ic_data_valid),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_grant(dc_grant), .dc_data_valid(dc_data_valid),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_ack(dc_wr_ack), .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_data_valid(mem_data_valid), .busy(busy)
  );

  int n_checks = 0, n_fail = 0;
  int cyc = 0, idle_from = 0, srv_i_until = 0, srv_d_until = 0;
  bit ic_pend = 1'b0, dc_pend = 1'b0, wr_pend = 1'b0, spur = 1'b0, rst_req = 1'b0;
  logic [15:0] ic_a = 16'h0, dc_a = 16'h0, wr_a = 16'h0, wr_d = 16'h0;

  // Expected behaviour per cycle (ring indexed by cycle number).
  bit exp_en[RING], exp_wr[RING], exp_ig[RING], exp_dg[RING], exp_busy[RING];
  bit own_i[RING], own_d[RING], ret[RING];
  logic [15:0] exp_addr[RING], exp_wd[RING];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_slot(input int i);
    exp_en[i] = 1'b0; exp_wr[i] = 1'b0; exp_ig[i] = 1'b0; exp_dg[i] = 1'b0;
    exp_busy[i] = 1'b0; own_i[i] = 1'b0; own_d[i] = 1'b0;
    exp_addr[i] = 16'h0; exp_wd[i] = 16'h0;
  endtask

  // A fill granted at t issues 8 reads at t+1..t+8, holds the grant to t+11,
  // and its words return LAT cycles after each issue.
  task automatic sched_fill(input int t, input logic [15:0] a, input bit is_i);
    for (int k = 0; k < 8; k++) begin
      exp_en[(t + 1 + k) % RING]   = 1'b1;
      exp_addr[(t + 1 + k) % RING] = {a[15:4], 4'h0} + 16'(2 * k);
      if (is_i) own_i[(t + 1 + LAT + k) % RING] = 1'b1;
      else      own_d[(t + 1 + LAT + k) % RING] = 1'b1;
    end
    for (int k = 1; k <= 11; k++) begin
      exp_busy[(t + k) % RING] = 1'b1;
      if (is_i) exp_ig[(t + k) % RING] = 1'b1;
      else      exp_dg[(t + k) % RING] = 1'b1;
    end
    idle_from = t + 12;
    if (is_i) srv_i_until = t + 12;
    else      srv_d_until = t + 12;
  endtask

  task automatic step();
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    idx = cyc % RING;
    rst        = rst_req;
    ic_req     = ic_pend;  ic_addr    = ic_a;
    dc_req     = dc_pend;  dc_addr    = dc_a;
    dc_wr_req  = wr_pend;  dc_wr_addr = wr_a;  dc_wr_data = wr_d;
    mem_data_valid = ret[idx] | spur;
    ret[idx] = 1'b0;
    if (rst_req) begin
      for (int i = 0; i < RING; i++) clear_slot(i);
      idle_from = cyc + 1; srv_i_until = 0; srv_d_until = 0;
    end else if (cyc >= idle_from) begin
      if (wr_pend) begin
        exp_en[(cyc + 1) % RING]   = 1'b1; exp_wr[(cyc + 1) % RING] = 1'b1;
        exp_busy[(cyc + 1) % RING] = 1'b1;
        exp_addr[(cyc + 1) % RING] = wr_a; exp_wd[(cyc + 1) % RING] = wr_d;
        idle_from = cyc + 2;
        wr_pend = 1'b0;
      end else if (dc_pend) begin
        sched_fill(cyc, dc_a, 1'b0);
        dc_pend = 1'b0;
      end else if (ic_pend) begin
        sched_fill(cyc, ic_a, 1'b1);
        ic_pend = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("busy",      busy,          exp_busy[idx]);
    check_eq("ic_grant",  ic_grant,      exp_ig[idx]);
    check_eq("dc_grant",  dc_grant,      exp_dg[idx]);
    check_eq("mem_en",    mem_enable,    exp_en[idx]);
    check_eq("mem_wr",    mem_wr,        exp_wr[idx]);
    check_eq("wr_ack",    dc_wr_ack,     exp_wr[idx]);
    check_eq("ic_dvalid", ic_data_valid, mem_data_valid & own_i[idx]);
    check_eq("dc_dvalid", dc_data_valid, mem_data_valid & own_d[idx]);
    if (exp_en[idx]) check_eq("mem_addr", mem_addr, exp_addr[idx]);
    if (exp_wr[idx]) check_eq("mem_wdata", mem_wdata, exp_wd[idx]);
    if (rst_req) begin
      check_eq("rst_addr",  mem_addr,  16'h0);
      check_eq("rst_wdata", mem_wdata, 16'h0);
    end
    if (mem_enable && !mem_wr) ret[(cyc + LAT) % RING] = 1'b1;
    clear_slot(idx);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < RING; i++) begin
      clear_slot(i);
      ret[i] = 1'b0;
    end
    rst_req = 1'b1; step(); rst_req = 1'b0;
    run(2);
    // Single I fill of line 0x123.
    ic_a = 16'h1234; ic_pend = 1'b1; run(16);
    // Simultaneous D and I fills.
    dc_a = 16'hA000; ic_a = 16'h0040; dc_pend = 1'b1; ic_pend = 1'b1; run(30);
    // Store beats both fills.
    wr_a = 16'h5556; wr_d = 16'hBEEF; dc_a = 16'h2020; ic_a = 16'h3030;
    wr_pend = 1'b1; dc_pend = 1'b1; ic_pend = 1'b1; run(32);
    // D request raised at beat 3 of an I fill.
    ic_a = 16'h4444; ic_pend = 1'b1; run(4);
    dc_a = 16'h6668; dc_pend = 1'b1; run(30);
    // Spurious returns while idle, then reset at beat 5 of a fill.
    spur = 1'b1; run(3); spur = 1'b0;
    ic_a = 16'h7770; ic_pend = 1'b1; run(6);
    rst_req = 1'b1; step(); rst_req = 1'b0;
    run(10);
    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      if (!ic_pend && cyc >= srv_i_until && $urandom_range(0, 9) == 0) begin
        ic_pend = 1'b1; ic_a = 16'($urandom);
      end
      if (!dc_pend && cyc >= srv_d_until && $urandom_range(0, 9) == 0) begin
        dc_pend = 1'b1; dc_a = 16'($urandom);
      end
      if (!wr_pend && $urandom_range(0, 11) == 0) begin
        wr_pend = 1'b1; wr_a = 16'($urandom); wr_d = 16'($urandom);
      end
      spur    = ($urandom_range(0, 15) == 0);
      rst_req = ($urandom_range(0, 299) == 0);
      step();
    end
    rst_req = 1'b0; spur = 1'b0;
    run(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
